// File: rtl/tx_tag_tracker_if.sv
// Request / issue / ACK / completion signal bundle for the TX tag tracker.
// The master side offers requests, ACKs and completion-ready; the slave side
// (the tracker) returns tag assignments, completions and occupancy.
interface tx_tag_tracker_if #(
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_read;
  logic [ADDR_W-1:0] req_addr;

  logic              iss_valid;
  logic [TAG_W-1:0]  iss_tag;
  logic              iss_is_read;
  logic [ADDR_W-1:0] iss_addr;

  logic              ack_valid;
  logic [TAG_W-1:0]  ack_tag;
  logic              ack_err;

  logic              cpl_valid;
  logic              cpl_ready;
  logic              cpl_is_read;
  logic [TAG_W-1:0]  cpl_tag;
  logic [ADDR_W-1:0] cpl_addr;

  logic [TAG_W:0]    outstanding;

  modport master (
    output req_valid, req_is_read, req_addr, ack_valid, ack_tag, cpl_ready,
    input  req_ready, iss_valid, iss_tag, iss_is_read, iss_addr, ack_err,
           cpl_valid, cpl_is_read, cpl_tag, cpl_addr, outstanding
  );

  modport slave (
    input  req_valid, req_is_read, req_addr, ack_valid, ack_tag, cpl_ready,
    output req_ready, iss_valid, iss_tag, iss_is_read, iss_addr, ack_err,
           cpl_valid, cpl_is_read, cpl_tag, cpl_addr, outstanding
  );
endinterface

// File: rtl/tx_tag_tracker.sv
// TX tag tracker: hands out the lowest free tag per request, stores the
// request address/type, matches ACKs to waiting tags and presents each
// acknowledged request as one completion through a single-entry valid/ready
// register. A tag returns to the free pool only when its completion is taken.
module tx_tag_tracker #(
  parameter int DEPTH  = 64,
  parameter int TAG_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,   // asynchronous, active-low
  tx_tag_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_OUT  = 2'd3
  } slot_state_e;

  slot_state_e       slot_q [DEPTH];
  slot_state_e       slot_d [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic              rd_q   [DEPTH];

  logic [DEPTH-1:0]  free_vec;
  logic [DEPTH-1:0]  wait_vec;
  logic [DEPTH-1:0]  done_vec;

  logic              free_found;
  logic [TAG_W-1:0]  free_tag;
  logic              done_found;
  logic [TAG_W-1:0]  done_tag;

  logic [TAG_W:0]    outstanding_q, outstanding_d;
  logic              iss_valid_q, iss_is_read_q;
  logic [TAG_W-1:0]  iss_tag_q;
  logic [ADDR_W-1:0] iss_addr_q;
  logic              ack_err_q;
  logic              cpl_valid_q, cpl_is_read_q;
  logic [TAG_W-1:0]  cpl_tag_q;
  logic [ADDR_W-1:0] cpl_addr_q;

  logic              req_ready;
  logic              alloc;
  logic              ack_hit;
  logic              cpl_fire;
  logic              cpl_load;

  // Per-slot state decode into flat vectors for the priority encoders.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_flags
    assign free_vec[gi] = (slot_q[gi] == S_FREE);
    assign wait_vec[gi] = (slot_q[gi] == S_WAIT);
    assign done_vec[gi] = (slot_q[gi] == S_DONE);
  end

  // Lowest-index FREE and DONE slots (descending scan leaves the lowest hit).
  always_comb begin
    free_found = |free_vec;
    done_found = |done_vec;
    free_tag   = '0;
    done_tag   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) free_tag = TAG_W'(i);
      if (done_vec[i]) done_tag = TAG_W'(i);
    end
  end

  assign req_ready = (outstanding_q != (TAG_W + 1)'(DEPTH));
  assign alloc     = bus.req_valid && req_ready;
  assign ack_hit   = bus.ack_valid && wait_vec[bus.ack_tag];
  assign cpl_fire  = cpl_valid_q && bus.cpl_ready;
  assign cpl_load  = (!cpl_valid_q || bus.cpl_ready) && done_found;

  // Slot transitions; each event only touches a slot in its source state, so
  // at most one of them applies to any given slot in a cycle.
  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && free_tag == TAG_W'(i)) begin
        slot_d[i] = S_WAIT;
      end else if (ack_hit && bus.ack_tag == TAG_W'(i)) begin
        slot_d[i] = S_DONE;
      end else if (cpl_load && done_tag == TAG_W'(i)) begin
        slot_d[i] = S_OUT;
      end else if (cpl_fire && cpl_tag_q == TAG_W'(i)) begin
        slot_d[i] = S_FREE;
      end
    end
  end

  // Occupancy: simultaneous alloc and completion handshake cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({alloc, cpl_fire})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Slot state table; reset frees every slot and drops in-flight requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= S_FREE;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Request payload storage; contents are meaningless while a slot is FREE.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[free_tag] <= bus.req_addr;
      rd_q[free_tag]   <= bus.req_is_read;
    end
  end

  // Registered issue, ACK-error and completion outputs plus occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
      iss_valid_q   <= 1'b0;
      iss_tag_q     <= '0;
      iss_is_read_q <= 1'b0;
      iss_addr_q    <= '0;
      ack_err_q     <= 1'b0;
      cpl_valid_q   <= 1'b0;
      cpl_tag_q     <= '0;
      cpl_is_read_q <= 1'b0;
      cpl_addr_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      iss_valid_q   <= alloc;
      if (alloc) begin
        iss_tag_q     <= free_tag;
        iss_is_read_q <= bus.req_is_read;
        iss_addr_q    <= bus.req_addr;
      end
      ack_err_q <= bus.ack_valid && !wait_vec[bus.ack_tag];
      // Register accepts a new completion when empty or being drained.
      if (!cpl_valid_q || bus.cpl_ready) begin
        cpl_valid_q <= done_found;
        if (done_found) begin
          cpl_tag_q     <= done_tag;
          cpl_is_read_q <= rd_q[done_tag];
          cpl_addr_q    <= addr_q[done_tag];
        end
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_tag     = iss_tag_q;
  assign bus.iss_is_read = iss_is_read_q;
  assign bus.iss_addr    = iss_addr_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.cpl_valid   = cpl_valid_q;
  assign bus.cpl_tag     = cpl_tag_q;
  assign bus.cpl_is_read = cpl_is_read_q;
  assign bus.cpl_addr    = cpl_addr_q;
  assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_tx_tag_tracker.sv
// Self-checking bench for tx_tag_tracker: table-driven allocations, then
// hand-written sequences for completion latency, full table, back-pressure,
// ACK errors and asynchronous reset. Issue and completion events are checked
// by scoreboard queues filled when the stimulus is driven.
module tb_tx_tag_tracker;

  localparam int DEPTH  = 64;
  localparam int TAG_W  = 6;
  localparam int ADDR_W = 32;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic              rd;
    logic [ADDR_W-1:0] addr;
  } ev_t;

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  exp_tag;
    logic [TAG_W:0]    exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tx_tag_tracker_if #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) bus ();

  tx_tag_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  ev_t iss_exp_q[$];
  ev_t cpl_exp_q[$];
  ev_t mon_ev;

  logic [ADDR_W-1:0] m_addr [DEPTH];
  logic              m_rd   [DEPTH];

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic rd, input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] exp_tag);
    chk("req_ready_before_req", 64'(bus.req_ready), 64'd1);
    bus.req_valid   = 1'b1;
    bus.req_is_read = rd;
    bus.req_addr    = addr;
    m_addr[exp_tag] = addr;
    m_rd[exp_tag]   = rd;
    iss_exp_q.push_back('{exp_tag, rd, addr});
    $display("req rd=%0d addr=%h expect tag=%0d", rd, addr, exp_tag);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_ack(input logic [TAG_W-1:0] tag);
    bus.ack_valid = 1'b1;
    bus.ack_tag   = tag;
    $display("ack tag=%0d", tag);
    tick();
    bus.ack_valid = 1'b0;
  endtask

  task automatic push_cpl(input logic [TAG_W-1:0] tag);
    cpl_exp_q.push_back('{tag, m_rd[tag], m_addr[tag]});
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.iss_valid) begin
        if (iss_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL iss_unexpected actual_tag=%0d required=none", bus.iss_tag);
        end else begin
          mon_ev = iss_exp_q.pop_front();
          $display("iss tag=%0d rd=%0d addr=%h", bus.iss_tag, bus.iss_is_read, bus.iss_addr);
          chk("iss_tag", 64'(bus.iss_tag), 64'(mon_ev.tag));
          chk("iss_is_read", 64'(bus.iss_is_read), 64'(mon_ev.rd));
          chk("iss_addr", 64'(bus.iss_addr), 64'(mon_ev.addr));
        end
      end
      if (bus.cpl_valid && bus.cpl_ready) begin
        if (cpl_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cpl_unexpected actual_tag=%0d required=none", bus.cpl_tag);
        end else begin
          mon_ev = cpl_exp_q.pop_front();
          $display("cpl tag=%0d rd=%0d addr=%h", bus.cpl_tag, bus.cpl_is_read, bus.cpl_addr);
          chk("cpl_tag", 64'(bus.cpl_tag), 64'(mon_ev.tag));
          chk("cpl_is_read", 64'(bus.cpl_is_read), 64'(mon_ev.rd));
          chk("cpl_addr", 64'(bus.cpl_addr), 64'(mon_ev.addr));
        end
      end
      if (bus.ack_err) err_cnt++;
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    bus.req_valid   = 1'b0;
    bus.req_is_read = 1'b0;
    bus.req_addr    = '0;
    bus.ack_valid   = 1'b0;
    bus.ack_tag     = '0;
    bus.cpl_ready   = 1'b0;

    vecs[0] = '{1'b0, 32'h100, 6'd0, 7'd1};
    vecs[1] = '{1'b0, 32'h104, 6'd1, 7'd2};
    vecs[2] = '{1'b0, 32'h108, 6'd2, 7'd3};
    vecs[3] = '{1'b1, 32'h10C, 6'd3, 7'd4};

    // Reset state
    tick();
    tick();
    chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
    chk("rst_ack_err", 64'(bus.ack_err), 64'd0);
    rst = 1'b1;
    tick();

    // Table-driven allocations: lowest tags in order, occupancy counting up
    for (int i = 0; i < 4; i++) begin
      do_req(vecs[i].rd, vecs[i].addr, vecs[i].exp_tag);
      chk("tbl_outstanding", 64'(bus.outstanding), 64'(vecs[i].exp_out));
    end

    // Completion latency: ACK edge, then register load one edge later
    bus.cpl_ready = 1'b1;
    push_cpl(6'd1);
    do_ack(6'd1);
    chk("cpl_not_same_edge", 64'(bus.cpl_valid), 64'd0);
    tick();
    chk("cpl_valid_next", 64'(bus.cpl_valid), 64'd1);
    chk("cpl_tag_direct", 64'(bus.cpl_tag), 64'd1);
    chk("cpl_addr_direct", 64'(bus.cpl_addr), 64'h104);
    chk("cpl_rd_direct", 64'(bus.cpl_is_read), 64'd0);
    tick();
    chk("out_after_cpl", 64'(bus.outstanding), 64'd3);
    chk("cpl_drained", 64'(bus.cpl_valid), 64'd0);
    do_req(1'b0, 32'h300, 6'd1);

    // Fill the whole table
    for (int i = 4; i < DEPTH; i++) begin
      do_req(1'(i % 2), 32'h1000 + 32'(i * 4), 6'(i));
    end
    chk("full_outstanding", 64'(bus.outstanding), 64'd64);
    chk("full_not_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hDEAD;
    for (int i = 0; i < 3; i++) tick();
    bus.req_valid = 1'b0;
    chk("full_no_issue", 64'(bus.iss_valid), 64'd0);
    chk("full_held_out", 64'(bus.outstanding), 64'd64);
    push_cpl(6'd63);
    do_ack(6'd63);
    tick();
    chk("full_ready_during_out", 64'(bus.req_ready), 64'd0);
    tick();
    chk("ready_after_free", 64'(bus.req_ready), 64'd1);
    chk("out_after_free", 64'(bus.outstanding), 64'd63);
    do_req(1'b1, 32'h5555, 6'd63);

    // Back-pressure: tag 5 is DONE one edge before tag 2, so the empty
    // register takes 5; the rest drain lowest-index first.
    bus.cpl_ready = 1'b0;
    do_ack(6'd5);
    do_ack(6'd2);
    do_ack(6'd9);
    do_ack(6'd7);
    push_cpl(6'd5);
    push_cpl(6'd2);
    push_cpl(6'd7);
    push_cpl(6'd9);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 64'(bus.cpl_valid), 64'd1);
      chk("hold_tag", 64'(bus.cpl_tag), 64'd5);
      tick();
    end
    bus.cpl_ready = 1'b1;
    tick();
    chk("b2b_tag2", 64'(bus.cpl_tag), 64'd2);
    tick();
    chk("b2b_tag7", 64'(bus.cpl_tag), 64'd7);
    tick();
    chk("b2b_tag9", 64'(bus.cpl_tag), 64'd9);
    tick();
    chk("b2b_drained", 64'(bus.cpl_valid), 64'd0);
    chk("b2b_outstanding", 64'(bus.outstanding), 64'd60);

    // ACK errors: FREE tag, DONE tag, OUT tag
    bus.cpl_ready = 1'b0;
    e0 = err_cnt;
    do_ack(6'd2);
    chk("err_free_pulse", 64'(bus.ack_err), 64'd1);
    tick();
    chk("err_pulse_end", 64'(bus.ack_err), 64'd0);
    do_ack(6'd10);
    chk("ack_ok_no_err", 64'(bus.ack_err), 64'd0);
    do_ack(6'd10);
    chk("err_done_pulse", 64'(bus.ack_err), 64'd1);
    do_ack(6'd10);
    chk("err_out_pulse", 64'(bus.ack_err), 64'd1);
    tick();
    chk("err_count3", 64'(err_cnt - e0), 64'd3);
    chk("err_out_unchanged", 64'(bus.outstanding), 64'd60);
    chk("err_cpl_tag", 64'(bus.cpl_tag), 64'd10);
    push_cpl(6'd10);
    bus.cpl_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("err_no_extra_cpl", 64'(bus.cpl_valid), 64'd0);
    chk("err_out_after", 64'(bus.outstanding), 64'd59);

    // ACK to the tag being allocated in the same cycle sees FREE
    bus.ack_valid = 1'b1;
    bus.ack_tag   = 6'd2;
    do_req(1'b1, 32'h777, 6'd2);
    bus.ack_valid = 1'b0;
    chk("err_same_cycle", 64'(bus.ack_err), 64'd1);
    tick();
    push_cpl(6'd2);
    do_ack(6'd2);
    tick();
    tick();
    tick();
    chk("err_count4", 64'(err_cnt - e0), 64'd4);
    chk("alloc_ack_out", 64'(bus.outstanding), 64'd59);

    // Asynchronous reset with 10 outstanding and a held completion
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) do_req(1'b0, 32'h2000 + 32'(i), 6'(i));
    bus.cpl_ready = 1'b0;
    do_ack(6'd4);
    tick();
    chk("pre_rst_cpl_valid", 64'(bus.cpl_valid), 64'd1);
    chk("pre_rst_outstanding", 64'(bus.outstanding), 64'd10);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
    chk("arst_outstanding", 64'(bus.outstanding), 64'd0);
    chk("arst_cpl_tag", 64'(bus.cpl_tag), 64'd0);
    chk("arst_cpl_addr", 64'(bus.cpl_addr), 64'd0);
    chk("arst_iss_tag", 64'(bus.iss_tag), 64'd0);
    chk("arst_iss_addr", 64'(bus.iss_addr), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    bus.cpl_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_no_cpl", 64'(bus.cpl_valid), 64'd0);
    do_req(1'b0, 32'hABC, 6'd0);
    chk("post_rst_outstanding", 64'(bus.outstanding), 64'd1);
    tick();

    chk("iss_queue_empty", 64'(iss_exp_q.size()), 64'd0);
    chk("cpl_queue_empty", 64'(cpl_exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
